level_fifo: RTL

//  Parametrised show-ahead synchronous FIFO, successor to depth_fifo, used on UART TX/RX data paths.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/level_fifo.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared width helpers and the status bundle for the level_fifo family.
package fifo_pkg;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int fifo_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for level_fifo: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int p_depth     = 8,
    parameter int p_word_size = 8
) (
    input  logic                           i_clk,
    input  logic                           i_wr_en,
    input  logic [fifo_ptr_w(p_depth)-1:0] i_wr_addr,
    input  logic [p_word_size-1:0]         i_wr_data,
    input  logic [fifo_ptr_w(p_depth)-1:0] i_rd_addr,
    output logic [p_word_size-1:0]         o_rd_data
);

    logic [p_word_size-1:0] r_mem [p_depth];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/level_fifo.sv
// Show-ahead synchronous FIFO with fill level, almost thresholds and sticky error flags.
// Define LEVEL_FIFO_CLEAR_EN to add the synchronous flush input clear_i.
module level_fifo
    import fifo_pkg::*;
#(
    parameter int p_depth        = 8,
    parameter int p_word_size    = 8,
    parameter int p_almost_full  = 6,
    parameter int p_almost_empty = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [p_word_size-1:0]         data_i,
    input  logic                           write_enable_i,
    input  logic                           read_enable_i,
    input  logic                           err_clear_i,
`ifdef LEVEL_FIFO_CLEAR_EN
    input  logic                           clear_i,
`endif
    output logic [p_word_size-1:0]         data_o,
    output logic                           read_valid_o,
    output logic                           full_o,
    output logic [fifo_lvl_w(p_depth)-1:0] level_o,
    output logic                           almost_full_o,
    output logic                           almost_empty_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int LP_PW = fifo_ptr_w(p_depth);
    localparam int LP_LW = fifo_lvl_w(p_depth);
    localparam logic [LP_PW-1:0] LP_LAST  = LP_PW'(p_depth - 1);
    localparam logic [LP_LW-1:0] LP_DEPTH = LP_LW'(p_depth);
    localparam logic [LP_LW-1:0] LP_AFULL = LP_LW'(p_almost_full);
    localparam logic [LP_LW-1:0] LP_AEMPT = LP_LW'(p_almost_empty);

    logic [LP_PW-1:0]       r_wr_ptr;
    logic [LP_PW-1:0]       r_rd_ptr;
    logic [LP_LW-1:0]       r_level;
    logic                   r_overflow;
    logic                   r_underflow;

    logic                   w_clear;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic                   w_ovf_evt;
    logic                   w_udf_evt;
    logic [p_word_size-1:0] w_head;
    fifo_status_t           w_status;

`ifdef LEVEL_FIFO_CLEAR_EN
    assign w_clear = clear_i;
`else
    assign w_clear = 1'b0;
`endif

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LP_DEPTH);

    // A flush discards concurrent traffic and raises no error flags.
    assign w_rd_acc  = read_enable_i && !w_empty && !w_clear;
    assign w_wr_acc  = write_enable_i && (!w_full || w_rd_acc) && !w_clear;
    assign w_ovf_evt = write_enable_i && w_full && !w_rd_acc && !w_clear;
    assign w_udf_evt = read_enable_i && w_empty && !w_clear;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_level <= r_level + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // A new error in the same cycle as err_clear_i keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (err_clear_i) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_evt) begin
                r_underflow <= 1'b1;
            end else if (err_clear_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .p_depth     (p_depth),
        .p_word_size (p_word_size)
    ) u_mem (
        .i_clk     (clk_i),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    always_comb begin
        w_status              = '0;
        w_status.full         = w_full;
        w_status.almost_full  = (r_level >= LP_AFULL);
        w_status.almost_empty = (r_level <= LP_AEMPT);
        w_status.overflow     = r_overflow;
        w_status.underflow    = r_underflow;
    end

    assign data_o         = w_empty ? '0 : w_head;
    assign read_valid_o   = !w_empty;
    assign level_o        = r_level;
    assign full_o         = w_status.full;
    assign almost_full_o  = w_status.almost_full;
    assign almost_empty_o = w_status.almost_empty;
    assign overflow_o     = w_status.overflow;
    assign underflow_o    = w_status.underflow;

endmodule
